// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-source enable, level/rising-edge mode, claim/complete.
// Optional macro EXT_INT_SYNC_EN adds a 2-flop synchronizer on every src line.
module ext_int_ctrl #(
  parameter int NUM_SOURCES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] src,
  input  logic                   sel,
  input  logic [3:0]             addr,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wenable,
  input  logic                   rd_en,
  output logic [31:0]            rdata,
  output logic                   mei_pending
);

  localparam int N = NUM_SOURCES;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_CLAIM   = 2'd2,
    REG_EDGE    = 2'd3
  } reg_sel_e;

  reg_sel_e       reg_sel;
  logic [N-1:0]   s;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   in_service_q, in_service_d;
  logic [N-1:0]   enable_q, enable_d;
  logic [N-1:0]   edge_q, edge_d;
  logic [N-1:0]   prev_q;
  logic [N-1:0]   lane_mask;
  logic [N-1:0]   eligible;
  logic [4:0]     winner_id;
  logic           mei_q;
  logic           claim_rd;
  logic           complete_wr;
  logic           unused_inputs;

  assign reg_sel       = reg_sel_e'(addr[3:2]);
  assign unused_inputs = ^{addr[1:0], wdata, wenable};

`ifdef EXT_INT_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = src;
`endif

  // Bit i of ENABLE/EDGE belongs to byte lane i/8.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < N; i++) lane_mask[i] = wenable[i/8];
  end

  assign claim_rd    = sel && rd_en && (reg_sel == REG_CLAIM);
  assign complete_wr = sel && wenable[0] && (reg_sel == REG_CLAIM);
  assign eligible    = pending_q & enable_q;

  always_comb begin
    winner_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) winner_id = 5'(i + 1);
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    enable_d     = enable_q;
    edge_d       = edge_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;

    if (sel && reg_sel == REG_ENABLE)
      enable_d = (enable_q & ~lane_mask) | (wdata[N-1:0] & lane_mask);
    if (sel && reg_sel == REG_EDGE)
      edge_d = (edge_q & ~lane_mask) | (wdata[N-1:0] & lane_mask);

    for (int i = 0; i < N; i++) begin
      logic claim_hit, complete_hit, rise;
      claim_hit    = claim_rd && (winner_id == 5'(i + 1));
      complete_hit = complete_wr && (wdata[4:0] == 5'(i + 1)) && in_service_q[i];
      rise         = s[i] & ~prev_q[i];

      // A rise in the claim cycle survives the claim, giving one-deep latching in service.
      if (edge_q[i]) pending_d[i] = (pending_q[i] & ~claim_hit) | rise;
      else           pending_d[i] = claim_hit ? 1'b0 : (s[i] & ~in_service_q[i]);

      in_service_d[i] = (in_service_q[i] & ~complete_hit) | claim_hit;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      edge_q       <= '0;
      prev_q       <= '0;
      mei_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      edge_q       <= edge_d;
      prev_q       <= s;
      mei_q        <= |eligible;
    end
  end

  assign mei_pending = mei_q;

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (reg_sel)
        REG_PENDING: rdata = 32'(pending_q);
        REG_ENABLE:  rdata = 32'(enable_q);
        REG_CLAIM:   rdata = 32'(winner_id);
        REG_EDGE:    rdata = 32'(edge_q);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Scoreboard bench for ext_int_ctrl (default build, no synchronizer): the driver queues
// expected values, a negedge monitor pops and compares rdata or mei_pending.
module tb_ext_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic        rd_en;
  logic [31:0] rdata;
  logic        mei_pending;

  ext_int_ctrl #(.NUM_SOURCES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src         (src),
    .sel         (sel),
    .addr        (addr),
    .wdata       (wdata),
    .wenable     (wenable),
    .rd_en       (rd_en),
    .rdata       (rdata),
    .mei_pending (mei_pending)
  );

  always #5 clk = ~clk;

  string       name_q[$];
  logic [31:0] exp_q[$];
  bit          is_mei_q[$];
  logic        obs = 1'b0;
  int          n_vec = 0;
  int          n_miss = 0;

  // Monitor: one observation per cycle in which the driver raises obs.
  always @(negedge clk) begin
    if (obs) begin
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard_empty: observation with no queued expectation at %0t", $time);
      end else begin
        string       nm;
        logic [31:0] ev, act;
        bit          m;
        nm  = name_q.pop_front();
        ev  = exp_q.pop_front();
        m   = is_mei_q.pop_front();
        act = m ? {31'b0, mei_pending} : rdata;
        n_vec++;
        if (act !== ev) begin
          n_miss++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, ev);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input string nm, input logic [31:0] v, input bit m);
    name_q.push_back(nm);
    exp_q.push_back(v);
    is_mei_q.push_back(m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] v, input string nm,
                    input bit s = 1'b1);
    sel   = s;
    rd_en = s;
    addr  = a;
    push_exp(nm, v, 1'b0);
    obs   = 1'b1;
    idle(1);
    sel   = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    obs   = 1'b0;
  endtask

  task automatic chk_mei(input logic v, input string nm);
    push_exp(nm, {31'b0, v}, 1'b1);
    obs = 1'b1;
    idle(1);
    obs = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we = 4'hF);
    sel     = 1'b1;
    addr    = a;
    wdata   = d;
    wenable = we;
    idle(1);
    sel     = 1'b0;
    addr    = '0;
    wdata   = '0;
    wenable = '0;
  endtask

  initial begin
    rst_n = 1'b0; src = '0; sel = 1'b0; addr = '0;
    wdata = '0; wenable = '0; rd_en = 1'b0;
    idle(1);
    chk_mei(1'b0, "mei_in_reset");
    rst_n = 1'b1;

    // Reset state of every register
    rd(4'h0, 32'h0, "rst_pending");
    rd(4'h4, 32'h0, "rst_enable");
    rd(4'h8, 32'h0, "rst_claim");
    rd(4'hC, 32'h0, "rst_edge");
    chk_mei(1'b0, "rst_mei");

    // Level source 1
    src = 4'b0001;
    wr(4'h4, 32'h1);
    idle(1);
    chk_mei(1'b1, "lvl_mei_set");
    rd(4'h0, 32'h1, "lvl_pending");
    rd(4'h8, 32'h1, "lvl_claim");
    chk_mei(1'b1, "lvl_mei_first_edge_after_claim");
    chk_mei(1'b0, "lvl_mei_second_edge_after_claim");
    idle(2);
    chk_mei(1'b0, "lvl_mei_in_service");
    rd(4'h8, 32'h0, "lvl_claim_busy");
    wr(4'h8, 32'h1, 4'h1);
    chk_mei(1'b0, "cpl_mei_edge0");
    chk_mei(1'b0, "cpl_mei_edge1");
    chk_mei(1'b1, "cpl_mei_reassert");
    rd(4'h8, 32'h1, "lvl_reclaim");
    src = 4'b0000;
    wr(4'h8, 32'h1, 4'h1);

    // Priority between sources 2 and 4
    src = 4'b1010;
    wr(4'h4, 32'hF);
    rd(4'h8, 32'h2, "prio_first");
    rd(4'h8, 32'h4, "prio_second");
    rd(4'h8, 32'h0, "prio_none");

    // Illegal completes must not release sources 2/4 (levels still high)
    wr(4'h8, 32'h0, 4'h1);
    wr(4'h8, 32'h7, 4'h1);
    wr(4'h8, 32'h6, 4'h1);
    wr(4'h8, 32'h1, 4'h1);
    idle(2);
    rd(4'h0, 32'h0, "illegal_cpl_pending");
    wr(4'h8, 32'h2, 4'h1);
    idle(1);
    rd(4'h0, 32'h2, "legal_cpl_repend");
    src = 4'b0000;
    rd(4'h8, 32'h2, "prio_reclaim");
    wr(4'h8, 32'h2, 4'h1);
    wr(4'h8, 32'h4, 4'h1);

    // Edge source 3
    wr(4'hC, 32'h4);
    wr(4'h4, 32'h4);
    rd(4'hC, 32'h4, "edge_readback");
    src = 4'b0100; idle(1); src = 4'b0000;
    rd(4'h0, 32'h4, "edge_pending");
    rd(4'h8, 32'h3, "edge_claim");
    rd(4'h0, 32'h0, "edge_cleared");
    src = 4'b0100; idle(1); src = 4'b0000;
    rd(4'h0, 32'h4, "edge_repend_in_service");
    wr(4'h8, 32'h3, 4'h1);
    rd(4'h8, 32'h3, "edge_claim_again");
    wr(4'h8, 32'h3, 4'h1);
    rd(4'h8, 32'h0, "edge_none");

    // Rising edge on source 1 in the same cycle as its claim
    wr(4'hC, 32'h1);
    wr(4'h4, 32'h1);
    src = 4'b0001; idle(1); src = 4'b0000; idle(1);
    src = 4'b0001;
    rd(4'h8, 32'h1, "coinc_claim");
    src = 4'b0000;
    rd(4'h0, 32'h1, "coinc_pending");
    rd(4'h8, 32'h1, "coinc_reclaim");
    wr(4'h8, 32'h1, 4'h1);

    // Masked level source 2
    wr(4'hC, 32'h0);
    wr(4'h4, 32'h0);
    src = 4'b0010;
    idle(2);
    rd(4'h0, 32'h2, "mask_pending");
    chk_mei(1'b0, "mask_mei");
    rd(4'h8, 32'h0, "mask_claim");
    wr(4'h4, 32'hF, 4'b1110);
    rd(4'h4, 32'h0, "lane_ignored");
    wr(4'h4, 32'h2, 4'b0001);
    rd(4'h4, 32'h2, "enable_readback");
    chk_mei(1'b1, "unmask_mei");
    rd(4'h4, 32'h0, "unsel_rdata", 1'b0);
    wr(4'h0, 32'hF);
    rd(4'h0, 32'h2, "pending_read_only");

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    chk_mei(1'b0, "async_rst_mei");
    rd(4'h4, 32'h0, "async_rst_enable");
    rd(4'h0, 32'h0, "async_rst_pending");
    src = 4'b0000;
    rst_n = 1'b1;
    idle(2);

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

Memory-mapped external interrupt controller that gathers up to `NUM_SOURCES` device interrupt lines into the single `mei_pending` input of the pipelined RV32 core. Each source can be enabled, masked, and configured as level- or rising-edge-triggered. Software claims the winning source with a read of the CLAIM register and retires it with a write to the same register. The block sits on the data bus behind the system address decoder, upstream of the core's interrupt logic.

## Interface
Parameters:
- `NUM_SOURCES`, default 4: number of interrupt lines, legal range 1..31. Source ids run from 1 to `NUM_SOURCES`; id 0 means "none".

Ports:
- `clk`  in  1  clock; everything samples on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `src`  in  NUM_SOURCES  raw device interrupt lines. Bit i is source id i+1.
- `sel`  in  1  block selected by the address decoder.
- `addr`  in  4  byte offset into the register window. Bits [1:0] are ignored.
- `wdata`  in  32  write data.
- `wenable`  in  4  byte-lane write strobes, same encoding as the core's `data_wenable`.
- `rd_en`  in  1  read strobe for the current access. It qualifies the claim side effect.
- `rdata`  out  32  read data. It is combinational from `sel`/`addr` and is 0 when `sel`=0.
- `mei_pending`  out  1  registered machine external interrupt request to the core.

## Operation
- Register map (word offsets):
  - 0x0 PENDING: read-only, pending[N-1:0]. Writes are ignored.
  - 0x4 ENABLE: read/write, honours byte lanes.
  - 0x8 CLAIM/COMPLETE.
  - 0xC EDGE: read/write, honours byte lanes. 1 = rising-edge source, 0 = level source.
- Unimplemented bits read as 0.
- Per-source state: `pending`, `in_service`, and `prev` (last synchronized level, used for edge detection).
- Level source, each cycle: `pending <= s & ~in_service`, where s is the synchronized level.
- Edge source: a rising edge (s & ~prev) sets `pending`. It is held until claimed, and an edge arriving while in service is still latched (one deep).
- Winner: the lowest-numbered source with `pending & enable`.
- Claim: a read of 0x8 with `sel & rd_en` returns the winner id.
  - If the winner is nonzero, the same clock edge clears that source's `pending` and sets its `in_service`.
  - With no winner the read returns 0 and changes no state.
- Complete: a write of 0x8 with `wenable[0]`, where wdata[4:0] = id, clears `in_service[id-1]`.
  - id 0, an id greater than `NUM_SOURCES`, or an id not in service is ignored.
- `mei_pending <= |(pending & enable)`.
- Simultaneous events on the same source:
  - Claim and a new edge in one cycle: `pending` stays 1 and `in_service` is set.
  - Complete and a level still high in one cycle: the source re-pends the following cycle.
  - Claim and a write to ENABLE in one cycle: the claim uses the pre-write enable.
- Disabling a source leaves its `pending` untouched; only `mei_pending` is masked.

## Timing
- Reset (asynchronous, immediate): all registers clear, namely pending, in_service, enable, edge, prev, and the synchronizer flops. `mei_pending`=0, and `rdata`=0 when `sel`=0.
- Register writes take effect at the clock edge of the access; a read of the same register on the next cycle returns the new value.
- Latency from a `src` change to `pending` is 1 cycle plus synchronizer depth (2 cycles with the synchronizer enabled, so 3 total). `mei_pending` follows `pending` one cycle later.
- After a claim, `mei_pending` deasserts on the second edge after the claim if no other source is eligible. Software must not assume it drops in the same cycle.
- A reset asserted mid-access aborts the access; no claim or complete side effect survives.

## Configuration
- `EXT_INT_SYNC_EN` defined: each `src` bit passes through a 2-flop synchronizer reset to 0. Sources may be asynchronous to `clk`.
- `EXT_INT_SYNC_EN` undefined: `src` is sampled directly by the `prev`/`pending` logic with no added latency. All sources must be synchronous to `clk`.

## Test plan
- Reset, then read all registers: PENDING, ENABLE, CLAIM and EDGE all read 0, and `mei_pending`=0.
- Level source: ENABLE=0x1, src[0] held high.
  - `mei_pending`=1, and a CLAIM read returns 1.
  - `mei_pending` returns to 0 and stays 0 while in service.
  - Writing COMPLETE=1 with src[0] still high reasserts `mei_pending`.
- Priority: ENABLE=0xF with src[3] and src[1] both pending.
  - First claim returns 2, second returns 4, third returns 0.
- Edge source: EDGE=0x4, ENABLE=0x4.
  - A 1-cycle pulse on src[2] latches pending, PENDING reads 0x4, and a claim returns 3.
  - A second pulse during service re-pends; a claim after complete returns 3 again.
- Edge coincident with claim: a rising edge on src[0] (edge mode) in the same cycle as its claim read leaves PENDING bit 0 = 1.
- Illegal complete writes (id 0, id 7 with N=4, or an id not in service) leave in_service unchanged.
- A masked source with pending=1 and ENABLE=0 keeps `mei_pending`=0, and a claim returns 0.
